// File: rtl/gc_pkg.sv
// gc_pkg: shared constants for the sensor filter block.
// State encodings, default debounce length, counter width.
package gc_pkg;

  localparam logic [1:0] OFF  = 2'd0;
  localparam logic [1:0] ON   = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  localparam int FILTER_LEN_DEF = 4;
  localparam int CNT_W          = 8;

  function automatic logic act_of(
    input logic [1:0] s
  );
    return (s == ON) || (s == HOLD);
  endfunction

endpackage

// File: rtl/gc_debounce.sv
// gc_debounce: 2-flop synchronizer plus run-length debouncer.
// Output follows input only after FILTER_LEN agreeing cycles.
module gc_debounce
  import gc_pkg::*;
#(
  parameter int FILTER_LEN = FILTER_LEN_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(FILTER_LEN - 1);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;

  // bring the raw level into the clk domain
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
    end
  end

  // count consecutive disagreeing cycles; accept at LAST
  always_ff @(posedge clk) begin
    if (rst) begin
      dout <= 1'b0;
      cnt  <= '0;
    end else if (s2 != dout) begin
      if (cnt == LAST) begin
        dout <= s2;
        cnt  <= '0;
      end else begin
        cnt  <= cnt + 1'b1;
      end
    end else begin
      cnt <= '0;
    end
  end

endmodule

// File: rtl/gc_sensor_filter.sv
// gc_sensor_filter: debounced sensor gating a Start-driven FSM.
// Actuator is high while the FSM sits in ON or HOLD.
module gc_sensor_filter
  import gc_pkg::*;
#(
  parameter int FILTER_LEN = FILTER_LEN_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Start,
  input  logic       Sensor,
  output logic       Actuator,
  output logic       sensor_filt,
  output logic [1:0] state
);

  logic       st1;
  logic       start_s;
  logic [1:0] nxt;

  gc_debounce #(
    .FILTER_LEN(FILTER_LEN)
  ) u_deb (
    .clk (clk),
    .rst (rst),
    .din (Sensor),
    .dout(sensor_filt)
  );

  // synchronize Start into the clk domain
  always_ff @(posedge clk) begin
    if (rst) begin
      st1     <= 1'b0;
      start_s <= 1'b0;
    end else begin
      st1     <= Start;
      start_s <= st1;
    end
  end

  // next state; a sensor drop always wins over Start
  always_comb begin
    nxt = OFF;
    unique case (1'b1)
      (state == OFF):
        nxt = (start_s && sensor_filt) ? ON : OFF;
      (state == ON):
        if (!sensor_filt)  nxt = OFF;
        else if (!start_s) nxt = HOLD;
        else               nxt = ON;
      (state == HOLD):
        if (!sensor_filt)  nxt = OFF;
        else if (start_s)  nxt = ON;
        else               nxt = HOLD;
      default:
        nxt = OFF;
    endcase
  end

  // state and Actuator move together on each edge
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= OFF;
      Actuator <= 1'b0;
    end else begin
      state    <= nxt;
      Actuator <= act_of(nxt);
    end
  end

endmodule

// File: tb/tb_gc_sensor_filter.sv
// tb_gc_sensor_filter: directed + random checks vs a window model.
// Model: filter flips once the last L synced samples all disagree.
module tb_gc_sensor_filter;

  localparam int L = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       Start;
  logic       Sensor;
  logic       Actuator;
  logic       sensor_filt;
  logic [1:0] state;

  int tests = 0;
  int fails = 0;

  // model state
  logic       m_s1, m_s2, m_e1, m_e2;
  logic       m_filt, m_act;
  logic [1:0] m_st;
  logic       hist[$];

  gc_sensor_filter #(
    .FILTER_LEN(L)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .Start      (Start),
    .Sensor     (Sensor),
    .Actuator   (Actuator),
    .sensor_filt(sensor_filt),
    .state      (state)
  );

  always #5 clk = ~clk;

  task automatic check(
    input string      tag,
    input logic [7:0] got,
    input logic [7:0] exp
  );
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s t=%0t got=%0h exp=%0h",
               tag, $time, got, exp);
    end
  endtask

  function automatic void model_edge(
    input logic st,
    input logic se,
    input logic r
  );
    logic [1:0] n;
    bit         all;
    if (r) begin
      m_s1 = 0; m_s2 = 0; m_e1 = 0; m_e2 = 0;
      m_filt = 0; m_act = 0; m_st = 2'd0;
      hist.delete();
      return;
    end
    // FSM from old synced start and old filter
    n = m_st;
    case (m_st)
      2'd0: n = (m_s2 && m_filt) ? 2'd1 : 2'd0;
      2'd1: n = !m_filt ? 2'd0 : (!m_s2 ? 2'd2 : 2'd1);
      2'd2: n = !m_filt ? 2'd0 : (m_s2 ? 2'd1 : 2'd2);
      default: n = 2'd0;
    endcase
    m_st  = n;
    m_act = (n == 2'd1) || (n == 2'd2);
    // debounce over a sliding window of synced samples
    hist.push_back(m_e2);
    if (hist.size() > L) void'(hist.pop_front());
    if (hist.size() == L) begin
      all = 1;
      foreach (hist[i]) if (hist[i] == m_filt) all = 0;
      if (all) m_filt = !m_filt;
    end
    m_s2 = m_s1; m_s1 = st;
    m_e2 = m_e1; m_e1 = se;
  endfunction

  task automatic step(
    input logic st,
    input logic se,
    input logic r
  );
    Start = st; Sensor = se; rst = r;
    @(posedge clk);
    model_edge(st, se, r);
    #1;
    check("act",   {7'd0, Actuator},    {7'd0, m_act});
    check("state", {6'd0, state},       {6'd0, m_st});
    check("filt",  {7'd0, sensor_filt}, {7'd0, m_filt});
  endtask

  task automatic stepn(
    input int   n,
    input logic st,
    input logic se
  );
    for (int i = 0; i < n; i++) step(st, se, 1'b0);
  endtask

  initial begin
    logic st, se;
    int   hold;
    m_s1 = 0; m_s2 = 0; m_e1 = 0; m_e2 = 0;
    m_filt = 0; m_act = 0; m_st = 0;

    // reset with arbitrary inputs
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    check("rst_act",   {7'd0, Actuator}, 8'd0);
    check("rst_state", {6'd0, state}, 8'd0);
    check("rst_filt",  {7'd0, sensor_filt}, 8'd0);

    // protocol sequence
    stepn(10, 1'b0, 1'b1);
    stepn(5, 1'b1, 1'b1);
    check("seq_on", {7'd0, Actuator}, 8'd1);
    stepn(6, 1'b1, 1'b0);
    check("seq_fall6", {7'd0, Actuator}, 8'd1);
    stepn(1, 1'b1, 1'b0);
    check("seq_fall7", {7'd0, Actuator}, 8'd0);
    stepn(6, 1'b1, 1'b1);
    check("seq_rise6", {7'd0, Actuator}, 8'd0);
    stepn(1, 1'b1, 1'b1);
    check("seq_rise7", {7'd0, Actuator}, 8'd1);
    stepn(5, 1'b0, 1'b1);
    check("hold_act",   {7'd0, Actuator}, 8'd1);
    check("hold_state", {6'd0, state}, 8'd2);
    // HOLD -> ON within 3 edges
    stepn(3, 1'b1, 1'b1);
    check("hold_on", {6'd0, state}, 8'd1);
    check("hold_on_act", {7'd0, Actuator}, 8'd1);

    // glitch rejection in ON
    stepn(3, 1'b1, 1'b0);
    stepn(8, 1'b1, 1'b1);
    check("glitch3_act", {7'd0, Actuator}, 8'd1);
    check("glitch3_filt", {7'd0, sensor_filt}, 8'd1);
    stepn(4, 1'b1, 1'b0);
    stepn(4, 1'b1, 1'b0);
    check("pulse4_filt", {7'd0, sensor_filt}, 8'd0);
    check("pulse4_act",  {7'd0, Actuator}, 8'd0);

    // Start alone never raises Actuator
    stepn(20, 1'b1, 1'b0);
    check("start_only", {7'd0, Actuator}, 8'd0);
    stepn(6, 1'b1, 1'b1);
    check("late_sens6", {7'd0, Actuator}, 8'd0);
    stepn(1, 1'b1, 1'b1);
    check("late_sens7", {7'd0, Actuator}, 8'd1);

    // reset mid-ON
    stepn(3, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    check("midrst_act",   {7'd0, Actuator}, 8'd0);
    check("midrst_state", {6'd0, state}, 8'd0);

    // random: sensor held for random runs, Start toggles
    st = 0; se = 0; hold = 0;
    for (int c = 0; c < 3000; c++) begin
      if (hold == 0) begin
        se   = $urandom_range(1, 0);
        hold = $urandom_range(8, 1);
      end
      hold--;
      if ($urandom_range(15, 0) == 0) st = !st;
      step(st, se, ($urandom_range(299, 0) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
